// File: rtl/reg_file_param.sv
// ---------------------------------------------------------------------------
// reg_file_param
// Parametrised register file with an integrated program-counter sequencer.
// Register 0 is the PC (owned by the sequencer); registers 1..NREG-1 are
// general purpose. Two write ports (ALU and load writeback), two
// combinational read ports, and a post-reset hold counter that gates all
// activity until `ready` rises.
//
// Optional feature macro: RF_BYPASS_EN
//   defined   -> same-cycle write data is forwarded to matching reads
//                (port B wins, address 0 never forwarded)
//   undefined -> reads always return the stored (pre-write) value
//
// Ports:
//   clk          in   clock, all state on posedge
//   rst_n        in   synchronous active-low reset
//   rd_en        in   read enable (outputs forced to 0 when low)
//   ra_addr      in   read port A address
//   rb_addr      in   read port B address
//   ra_data      out  read port A data (combinational)
//   rb_data      out  read port B data (combinational)
//   wa_en/addr/data  in  write port A (ALU writeback)
//   wb_en/addr/data  in  write port B (load writeback), wins on conflict
//   jmp, jmp_target      in  jump request and base address
//   redirect, redirect_pc in redirect request and base address
//   freeze       in   hold PC
//   pc_out       out  registered PC (register 0)
//   ready        out  high once the reset hold has completed
// ---------------------------------------------------------------------------
module reg_file_param #(
  parameter int DATA_W   = 16,
  parameter int NREG     = 8,
  parameter int ADDR_W   = $clog2(NREG),
  parameter int PC_STEP  = 1,
  parameter int RST_HOLD = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              rd_en,
  input  logic [ADDR_W-1:0] ra_addr,
  input  logic [ADDR_W-1:0] rb_addr,
  output logic [DATA_W-1:0] ra_data,
  output logic [DATA_W-1:0] rb_data,
  input  logic              wa_en,
  input  logic [ADDR_W-1:0] wa_addr,
  input  logic [DATA_W-1:0] wa_data,
  input  logic              wb_en,
  input  logic [ADDR_W-1:0] wb_addr,
  input  logic [DATA_W-1:0] wb_data,
  input  logic              jmp,
  input  logic [DATA_W-1:0] jmp_target,
  input  logic              redirect,
  input  logic [DATA_W-1:0] redirect_pc,
  input  logic              freeze,
  output logic [DATA_W-1:0] pc_out,
  output logic              ready
);

  localparam logic [DATA_W-1:0] STEP = DATA_W'(PC_STEP);

  logic [DATA_W-1:0] r_pc;
  logic              r_ready;
  logic [3:0]        r_hold;
  logic [DATA_W-1:0] r_regs [1:NREG-1];

  logic [NREG-1:1]   w_we;
  logic [DATA_W-1:0] w_wd      [1:NREG-1];
  logic [DATA_W-1:0] w_rd_view [0:NREG-1];
  logic              w_rd_ok;

  // Hold counter and PC sequencer. The counter only runs while ready is
  // low; once it reaches zero ready latches high until the next reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_pc    <= '0;
      r_ready <= 1'b0;
      r_hold  <= 4'(RST_HOLD);
    end else if (!r_ready) begin
      if (r_hold == 4'd0) begin
        r_ready <= 1'b1;
      end else begin
        r_hold <= r_hold - 4'd1;
      end
    end else begin
      if (redirect) begin
        r_pc <= redirect_pc + STEP;
      end else if (jmp) begin
        r_pc <= jmp_target + STEP;
      end else if (!freeze) begin
        r_pc <= r_pc + STEP;
      end
    end
  end

  // Per-register write decode. Address 0 has no entry here, so writes to
  // the PC slot simply fall on the floor. Port B takes priority.
  genvar gi;
  generate
    for (gi = 1; gi < NREG; gi++) begin : g_wr
      logic w_hit_a;
      logic w_hit_b;
      assign w_hit_a   = wa_en && (wa_addr == ADDR_W'(gi));
      assign w_hit_b   = wb_en && (wb_addr == ADDR_W'(gi));
      assign w_we[gi]  = r_ready && (w_hit_a || w_hit_b);
      assign w_wd[gi]  = w_hit_b ? wb_data : wa_data;
      assign w_rd_view[gi] = r_regs[gi];
    end
  endgenerate

  assign w_rd_view[0] = r_pc;

  always_ff @(posedge clk) begin
    for (int i = 1; i < NREG; i++) begin
      if (!rst_n) begin
        r_regs[i] <= '0;
      end else if (w_we[i]) begin
        r_regs[i] <= w_wd[i];
      end
    end
  end

  // Read ports: index 0 selects port A, index 1 selects port B.
  generate
    for (gi = 0; gi < 2; gi++) begin : g_rd
      logic [ADDR_W-1:0] w_addr;
      logic [DATA_W-1:0] w_val;
      assign w_addr = (gi == 0) ? ra_addr : rb_addr;
      always_comb begin
        w_val = w_rd_view[w_addr];
`ifdef RF_BYPASS_EN
        // Forward same-cycle write data; B is checked last so it wins.
        if (w_addr != '0 && r_ready) begin
          if (wa_en && (wa_addr == w_addr)) w_val = wa_data;
          if (wb_en && (wb_addr == w_addr)) w_val = wb_data;
        end
`endif
      end
    end
  endgenerate

  // rst_n gates the read outputs combinationally, not just via r_ready.
  assign w_rd_ok = rd_en && rst_n && r_ready;
  assign ra_data = w_rd_ok ? g_rd[0].w_val : '0;
  assign rb_data = w_rd_ok ? g_rd[1].w_val : '0;
  assign pc_out  = r_pc;
  assign ready   = r_ready;

endmodule

// File: tb/tb_reg_file_param.sv
module tb_reg_file_param;

`ifdef RF_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        rd_en;
  logic [2:0]  ra_addr, rb_addr, wa_addr, wb_addr;
  logic [15:0] ra_data, rb_data, wa_data, wb_data;
  logic        wa_en, wb_en, jmp, redirect, freeze, ready;
  logic [15:0] jmp_target, redirect_pc, pc_out;

  int n_checks = 0;
  int n_errors = 0;

  reg_file_param #(.DATA_W(16), .NREG(8), .PC_STEP(1), .RST_HOLD(1)) dut (
    .clk(clk), .rst_n(rst_n), .rd_en(rd_en),
    .ra_addr(ra_addr), .rb_addr(rb_addr), .ra_data(ra_data), .rb_data(rb_data),
    .wa_en(wa_en), .wa_addr(wa_addr), .wa_data(wa_data),
    .wb_en(wb_en), .wb_addr(wb_addr), .wb_data(wb_data),
    .jmp(jmp), .jmp_target(jmp_target), .redirect(redirect), .redirect_pc(redirect_pc),
    .freeze(freeze), .pc_out(pc_out), .ready(ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        rd_en;
    logic [2:0]  ra, rb;
    logic        wa_en;
    logic [2:0]  wa_addr;
    logic [15:0] wa_data;
    logic        wb_en;
    logic [2:0]  wb_addr;
    logic [15:0] wb_data;
    logic        jmp;
    logic [15:0] jt;
    logic        redir;
    logic [15:0] rpc;
    logic        frz;
    logic [15:0] exp_ra, exp_rb, exp_pc;
  } vec_t;

  vec_t vecs [17];

  function automatic vec_t mk(logic rd, logic [2:0] ra, logic [2:0] rb,
                              logic wae, logic [2:0] waa, logic [15:0] wad,
                              logic wbe, logic [2:0] wba, logic [15:0] wbd,
                              logic j, logic [15:0] jt, logic r, logic [15:0] rpc,
                              logic f, logic [15:0] era, logic [15:0] erb,
                              logic [15:0] epc);
    vec_t v;
    v.rd_en = rd; v.ra = ra; v.rb = rb;
    v.wa_en = wae; v.wa_addr = waa; v.wa_data = wad;
    v.wb_en = wbe; v.wb_addr = wba; v.wb_data = wbd;
    v.jmp = j; v.jt = jt; v.redir = r; v.rpc = rpc; v.frz = f;
    v.exp_ra = era; v.exp_rb = erb; v.exp_pc = epc;
    return v;
  endfunction

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  task automatic idle_inputs();
    rd_en = 1'b1; ra_addr = 3'd0; rb_addr = 3'd0;
    wa_en = 1'b0; wa_addr = 3'd0; wa_data = 16'h0;
    wb_en = 1'b0; wb_addr = 3'd0; wb_data = 16'h0;
    jmp = 1'b0; jmp_target = 16'h0; redirect = 1'b0; redirect_pc = 16'h0;
    freeze = 1'b0;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // Starting state after the reset sequence: PC = 1, all GPRs = 0.
    vecs[0]  = mk(1,0,1, 0,0,16'h0, 0,0,16'h0, 1,16'h0100, 1,16'h0040, 0, 16'h0001, 16'h0000, 16'h0041);
    vecs[1]  = mk(1,0,0, 0,0,16'h0, 0,0,16'h0, 1,16'h0100, 0,16'h0,    0, 16'h0041, 16'h0041, 16'h0101);
    vecs[2]  = mk(1,0,0, 0,0,16'h0, 0,0,16'h0, 0,16'h0,    0,16'h0,    1, 16'h0101, 16'h0101, 16'h0101);
    vecs[3]  = mk(1,3,0, 1,3,16'h1111, 1,3,16'h2222, 0,16'h0, 0,16'h0, 1,
                  BYP ? 16'h2222 : 16'h0000, 16'h0101, 16'h0101);
    vecs[4]  = mk(1,3,0, 1,0,16'h5555, 1,2,16'h00FF, 0,16'h0, 0,16'h0, 1, 16'h2222, 16'h0101, 16'h0101);
    vecs[5]  = mk(0,2,3, 0,0,16'h0, 0,0,16'h0, 0,16'h0, 0,16'h0, 1, 16'h0000, 16'h0000, 16'h0101);
    vecs[6]  = mk(1,2,0, 0,0,16'h0, 0,0,16'h0, 0,16'h0, 0,16'h0, 0, 16'h00FF, 16'h0101, 16'h0102);
    vecs[7]  = mk(1,5,5, 1,5,16'hABCD, 0,0,16'h0, 0,16'h0, 0,16'h0, 1,
                  BYP ? 16'hABCD : 16'h0000, BYP ? 16'hABCD : 16'h0000, 16'h0102);
    vecs[8]  = mk(1,5,2, 0,0,16'h0, 0,0,16'h0, 0,16'h0, 0,16'h0, 0, 16'hABCD, 16'h00FF, 16'h0103);
    vecs[9]  = mk(1,0,5, 0,0,16'h0, 0,0,16'h0, 0,16'h0, 1,16'hFFFD, 0, 16'h0103, 16'hABCD, 16'hFFFE);
    vecs[10] = mk(1,0,3, 0,0,16'h0, 0,0,16'h0, 0,16'h0, 0,16'h0, 0, 16'hFFFE, 16'h2222, 16'hFFFF);
    vecs[11] = mk(1,0,0, 0,0,16'h0, 0,0,16'h0, 0,16'h0, 0,16'h0, 0, 16'hFFFF, 16'hFFFF, 16'h0000);
    vecs[12] = mk(1,0,0, 0,0,16'h0, 0,0,16'h0, 0,16'h0, 0,16'h0, 0, 16'h0000, 16'h0000, 16'h0001);
    vecs[13] = mk(1,1,6, 1,1,16'h1234, 1,6,16'h5678, 0,16'h0, 0,16'h0, 1,
                  BYP ? 16'h1234 : 16'h0000, BYP ? 16'h5678 : 16'h0000, 16'h0001);
    vecs[14] = mk(1,1,6, 0,0,16'h0, 0,0,16'h0, 0,16'h0, 0,16'h0, 1, 16'h1234, 16'h5678, 16'h0001);
    vecs[15] = mk(1,7,4, 0,0,16'h0, 0,0,16'h0, 1,16'h0200, 0,16'h0, 1, 16'h0000, 16'h0000, 16'h0201);
    vecs[16] = mk(1,0,0, 0,0,16'h0, 0,0,16'h0, 0,16'h0, 1,16'h0010, 1, 16'h0201, 16'h0201, 16'h0011);

    // Reset hold: rst_n low for 3 cycles, then release.
    idle_inputs();
    rst_n = 1'b0;
    repeat (3) tick();
    check("rst_ready", {15'h0, ready}, 16'h0000);
    check("rst_pc", pc_out, 16'h0000);
    check("rst_ra", ra_data, 16'h0000);
    rst_n = 1'b1;
    tick();
    $display("release+1: ready=%b pc=%h", ready, pc_out);
    check("hold1_ready", {15'h0, ready}, 16'h0000);
    check("hold1_pc", pc_out, 16'h0000);
    check("hold1_ra", ra_data, 16'h0000);
    tick();
    $display("release+2: ready=%b pc=%h", ready, pc_out);
    check("hold2_ready", {15'h0, ready}, 16'h0001);
    check("hold2_pc", pc_out, 16'h0000);
    tick();
    $display("release+3: ready=%b pc=%h", ready, pc_out);
    check("hold3_pc", pc_out, 16'h0001);

    // Table-driven vectors: reads checked before the edge, PC after it.
    for (int i = 0; i < 17; i++) begin
      rd_en = vecs[i].rd_en; ra_addr = vecs[i].ra; rb_addr = vecs[i].rb;
      wa_en = vecs[i].wa_en; wa_addr = vecs[i].wa_addr; wa_data = vecs[i].wa_data;
      wb_en = vecs[i].wb_en; wb_addr = vecs[i].wb_addr; wb_data = vecs[i].wb_data;
      jmp = vecs[i].jmp; jmp_target = vecs[i].jt;
      redirect = vecs[i].redir; redirect_pc = vecs[i].rpc; freeze = vecs[i].frz;
      #1;
      check($sformatf("v%0d_ra", i), ra_data, vecs[i].exp_ra);
      check($sformatf("v%0d_rb", i), rb_data, vecs[i].exp_rb);
      tick();
      check($sformatf("v%0d_pc", i), pc_out, vecs[i].exp_pc);
      $display("vec %0d: ra=%h rb=%h pc=%h", i, vecs[i].exp_ra, vecs[i].exp_rb, pc_out);
    end

    // Mid-run reset overriding a pending jump and write.
    idle_inputs();
    ra_addr = 3'd1; rb_addr = 3'd2;
    jmp = 1'b1; jmp_target = 16'h0300;
    wa_en = 1'b1; wa_addr = 3'd1; wa_data = 16'hBEEF;
    rst_n = 1'b0;
    #1;
    check("midrst_ra_comb", ra_data, 16'h0000);
    check("midrst_rb_comb", rb_data, 16'h0000);
    tick();
    $display("mid-run reset: ready=%b pc=%h", ready, pc_out);
    check("midrst_pc", pc_out, 16'h0000);
    check("midrst_ready", {15'h0, ready}, 16'h0000);
    idle_inputs();
    ra_addr = 3'd1; rb_addr = 3'd2;
    rst_n = 1'b1;
    tick();
    check("midrst_hold_ready", {15'h0, ready}, 16'h0000);
    tick();
    $display("post-reset ready: ready=%b pc=%h r1=%h r2=%h", ready, pc_out, ra_data, rb_data);
    check("midrst_ready2", {15'h0, ready}, 16'h0001);
    check("midrst_r1_cleared", ra_data, 16'h0000);
    check("midrst_r2_cleared", rb_data, 16'h0000);
    tick();
    check("midrst_pc_inc", pc_out, 16'h0001);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
